// File: rtl/lsu_pkg.sv
// Shared core definitions for the load/store sequencer: DRAM access codes,
// sequencer state type and byte-enable masks.
package lsu_pkg;

  // Load codes, consumed by write-back for sign/zero extension.
  localparam logic [2:0] DRAM_RD_B  = 3'b000;
  localparam logic [2:0] DRAM_RD_H  = 3'b001;
  localparam logic [2:0] DRAM_RD_W  = 3'b010;
  localparam logic [2:0] DRAM_RD_BU = 3'b100;
  localparam logic [2:0] DRAM_RD_HU = 3'b101;

  // Store codes share the size encoding of the signed load codes.
  localparam logic [2:0] DRAM_WR_B  = 3'b000;
  localparam logic [2:0] DRAM_WR_H  = 3'b001;
  localparam logic [2:0] DRAM_WR_W  = 3'b010;

  localparam logic [3:0] LSU_BE_B = 4'b0001;
  localparam logic [3:0] LSU_BE_H = 4'b0011;
  localparam logic [3:0] LSU_BE_W = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } lsu_state_t;

  // Unshifted byte mask for an access code; unknown codes act as words.
  function automatic logic [3:0] lsu_size_mask(input logic [2:0] sel);
    case (sel)
      DRAM_RD_B, DRAM_RD_BU: lsu_size_mask = LSU_BE_B;
      DRAM_RD_H, DRAM_RD_HU: lsu_size_mask = LSU_BE_H;
      default:               lsu_size_mask = LSU_BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: misalignment check, beat count, per-beat
// byte enables / write data and the read-lane shift.
// Macro LSU_SPLIT_EN: word-crossing accesses are split into two beats
// instead of being rejected.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        reject,
  output logic        two_beats,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] lane_mask,
  output logic [4:0]  rd_shift
);

  logic [3:0] mask;
  logic [7:0] be_wide;
  logic       misalign;

  // Derive all lane information from access size and byte offset.
  always_comb begin
    mask      = lsu_size_mask(sel);
    be_wide   = {4'b0000, mask} << off;
    misalign  = ((mask == LSU_BE_H) && off[0]) ||
                ((mask == LSU_BE_W) && (off != 2'b00));
    be0       = be_wide[3:0];
    be1       = be_wide[7:4];
    lane_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    rd_shift  = {off, 3'b000};
    if (mask == LSU_BE_B)      wdata0 = {4{wdata[7:0]}};
    else if (mask == LSU_BE_H) wdata0 = {2{wdata[15:0]}};
    else                       wdata0 = wdata;
    wdata1    = '0;
`ifdef LSU_SPLIT_EN
    reject    = 1'b0;
    two_beats = |be_wide[7:4];
    // Replication only lines up for aligned data; misaligned data is shifted.
    if (misalign) begin
      wdata0 = wdata << rd_shift;
      wdata1 = wdata >> (6'd32 - {1'b0, rd_shift});
    end
`else
    reject    = misalign;
    two_beats = 1'b0;
`endif
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer between execute and the data-memory port.
// One access at a time, req/gnt/rvalid handshake, timeout abort.
// Macro LSU_SPLIT_EN enables two-beat word-crossing accesses (REQ1/WAIT1).
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_sel_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            stall_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_t      state, state_nx;
  logic [CW-1:0]   cnt;
  logic            tmo, hi;
  logic            err_q, err_nx, we_q, two_q;
  logic [XLEN-3:0] word_q;
  logic [3:0]      be0_q, be1_q;
  logic [XLEN-1:0] wd0_q, wd1_q, lmask_q, cap_lo, cap_hi, rd_sh;
  logic [4:0]      shift_q;

  logic            a_reject, a_two;
  logic [3:0]      a_be0, a_be1;
  logic [31:0]     a_wd0, a_wd1, a_lmask;
  logic [4:0]      a_shift;

  lsu_align u_align (
    .sel       (req_sel_i),
    .off       (req_addr_i[1:0]),
    .wdata     (req_wdata_i),
    .reject    (a_reject),
    .two_beats (a_two),
    .be0       (a_be0),
    .be1       (a_be1),
    .wdata0    (a_wd0),
    .wdata1    (a_wd1),
    .lane_mask (a_lmask),
    .rd_shift  (a_shift)
  );

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  // Next-state and error flag; grant/rvalid win over a same-cycle timeout.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      S_IDLE: if (req_valid_i) begin
        state_nx = a_reject ? S_RESP : S_REQ0;
        err_nx   = a_reject;
      end
      S_REQ0: begin
        if (mem_gnt_i)  state_nx = we_q ? (two_q ? S_REQ1 : S_RESP) : S_WAIT0;
        else if (tmo) begin state_nx = S_RESP; err_nx = 1'b1; end
      end
      S_WAIT0: begin
        if (mem_rvalid_i) state_nx = two_q ? S_REQ1 : S_RESP;
        else if (tmo) begin state_nx = S_RESP; err_nx = 1'b1; end
      end
`ifdef LSU_SPLIT_EN
      S_REQ1: begin
        if (mem_gnt_i)  state_nx = we_q ? S_RESP : S_WAIT1;
        else if (tmo) begin state_nx = S_RESP; err_nx = 1'b1; end
      end
      S_WAIT1: begin
        if (mem_rvalid_i) state_nx = S_RESP;
        else if (tmo) begin state_nx = S_RESP; err_nx = 1'b1; end
      end
`endif
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, timeout counter, request capture and read-data capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      two_q   <= 1'b0;
      word_q  <= '0;
      be0_q   <= '0;
      be1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
      lmask_q <= '0;
      shift_q <= '0;
      cap_lo  <= '0;
      cap_hi  <= '0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      // Every state change is an entry, so the counter restarts on each one.
      cnt   <= (state_nx == state && state != S_IDLE) ? cnt + CW'(1) : '0;
      if (state == S_IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        two_q   <= a_two;
        word_q  <= req_addr_i[XLEN-1:2];
        be0_q   <= a_be0;
        be1_q   <= a_be1;
        wd0_q   <= a_wd0;
        wd1_q   <= a_wd1;
        lmask_q <= a_lmask;
        shift_q <= a_shift;
        cap_lo  <= '0;
        cap_hi  <= '0;
      end
      if (state == S_WAIT0 && mem_rvalid_i) cap_lo <= mem_rdata_i;
      if (state == S_WAIT1 && mem_rvalid_i) cap_hi <= mem_rdata_i;
    end
  end

  // Memory-side and pipeline-side outputs decoded from state.
  always_comb begin
    hi           = (state == S_REQ1);
    req_ready_o  = (state == S_IDLE);
    stall_o      = (state != S_IDLE);
    mem_req_o    = (state == S_REQ0) || hi;
    mem_we_o     = mem_req_o & we_q;
    mem_addr_o   = mem_req_o ? {word_q + {{(XLEN-3){1'b0}}, hi}, 2'b00} : '0;
    mem_be_o     = mem_req_o ? (hi ? be1_q : be0_q) : '0;
    mem_wdata_o  = mem_we_o ? (hi ? wd1_q : wd0_q) : '0;
    resp_valid_o = (state == S_RESP);
    resp_err_o   = resp_valid_o & err_q;
    rd_sh        = XLEN'({cap_hi, cap_lo} >> shift_q);
    resp_rdata_o = (resp_valid_o & ~we_q & ~err_q) ? (rd_sh & lmask_q) : '0;
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Randomized self-checking bench for lsu_seq with a transaction-level model
// that schedules the expected outputs of every cycle.
module tb_lsu_seq;
  import lsu_pkg::*;

  localparam int unsigned TO = 12;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_we;
  logic [2:0]  req_sel;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_seq #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_sel_i(req_sel), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .stall_o(stall),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;

  logic        e_ready, e_stall, e_req, e_we, e_rv, e_err;
  logic [31:0] e_addr, e_wd, e_rd;
  logic [3:0]  e_be;

  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_be;
  logic        o_err;
  int          o_resp_cyc = 0, o_req_cycles = 0, o_resp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Compare every output against the scheduled expectation, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("mem_req", {31'b0, mem_req}, {31'b0, e_req});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
      chk("mem_wdata", mem_wdata, e_wd);
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_rv});
      chk("resp_err", {31'b0, resp_err}, {31'b0, e_err});
      chk("resp_rdata", resp_rdata, e_rd);
      if (resp_valid) begin
        o_rd = resp_rdata; o_err = resp_err; o_resp_cyc = cyc; o_resp_cnt++;
      end
      if (mem_req) begin
        o_addr = mem_addr; o_be = mem_be; o_wd = mem_wdata; o_req_cycles++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cyc(input logic rdy, input logic stl, input logic rq, input logic we,
                            input logic [31:0] ad, input logic [3:0] be, input logic [31:0] wd,
                            input logic rv, input logic er, input logic [31:0] rd);
    e_ready = rdy; e_stall = stl; e_req = rq; e_we = we; e_addr = ad;
    e_be = be; e_wd = wd; e_rv = rv; e_err = er; e_rd = rd;
  endtask

  task automatic expect_idle();
    expect_cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Stray read-data pulses outside WAIT states must be ignored.
  task automatic noise();
    mem_rvalid = ($urandom_range(0, 3) == 0);
    mem_rdata  = $urandom;
  endtask

  // One transaction from its accept cycle through RESP; leaves the bench in
  // the following IDLE cycle with idle expectations set.
  task automatic do_txn(input bit we, input logic [2:0] sel, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd0, input logic [31:0] rd1,
                        input int g0, input int g1, input int r0, input int r1, output int acc);
    int          n, off, nb;
    bit          err;
    logic [31:0] ba[2], bw[2], rdv[2], got[2];
    logic [3:0]  bb[2];
    int          gd[2], rdl[2];
    logic [7:0]  bew;
    logic [63:0] both;
    logic [31:0] lm, exp_rd;

    n   = (sel == DRAM_RD_B || sel == DRAM_RD_BU) ? 1 :
          (sel == DRAM_RD_H || sel == DRAM_RD_HU) ? 2 : 4;
    off = int'(addr[1:0]);
    bew = 8'(((1 << n) - 1) << off);
    nb  = 1; err = 1'b0;
    bw[0] = '0; bw[1] = '0;
    if (off % n != 0) begin
`ifdef LSU_SPLIT_EN
      nb    = (off + n > 4) ? 2 : 1;
      bw[0] = wdata << (8 * off);
      bw[1] = wdata >> (8 * (4 - off));
`else
      nb  = 0;
      err = 1'b1;
`endif
    end else begin
      bw[0] = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
    end
    ba[0] = addr & ~32'h3; ba[1] = ba[0] + 32'd4;
    bb[0] = bew[3:0];      bb[1] = bew[7:4];
    rdv[0] = rd0; rdv[1] = rd1; got[0] = '0; got[1] = '0;
    gd[0] = g0; gd[1] = g1; rdl[0] = r0; rdl[1] = r1;

    acc = cyc;
    expect_idle();
    req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; noise();
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_sel = 3'($urandom);

    for (int b = 0; b < nb && !err; b++) begin
      for (int k = 0; k < int'(TO); k++) begin
        expect_cyc(1'b0, 1'b1, 1'b1, we, ba[b], bb[b], we ? bw[b] : 32'h0, 1'b0, 1'b0, '0);
        mem_gnt = (k == gd[b]); noise();
        if (k == gd[b]) begin step(); break; end
        if (k == int'(TO) - 1) begin err = 1'b1; step(); break; end
        step();
      end
      mem_gnt = 1'b0;
      if (!err && !we) begin
        for (int k = 0; k < int'(TO); k++) begin
          expect_cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
          mem_rvalid = (k == rdl[b]);
          mem_rdata  = mem_rvalid ? rdv[b] : $urandom;
          if (k == rdl[b]) begin got[b] = rdv[b]; step(); break; end
          if (k == int'(TO) - 1) begin err = 1'b1; step(); break; end
          step();
        end
      end
    end

    lm     = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    both   = {got[1], got[0]} >> (8 * off);
    exp_rd = (we || err) ? 32'h0 : (both[31:0] & lm);
    expect_cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, err, exp_rd);
    mem_gnt = 1'b0; noise();
    step();
    expect_idle();
    noise();
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 15) == 0) ? int'(TO) + 5 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    int acc, snap, snap2;
    bit we;
    logic [2:0] sel;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = '0; req_addr = '0;
    req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    expect_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(); step();
    rst = 1'b0;

    // Aligned word load, zero-wait memory.
    do_txn(1'b0, DRAM_RD_W, 32'h100, $urandom, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, acc);
    chk("tp1_latency", o_resp_cyc - acc, 3);
    chk("tp1_rdata", o_rd, 32'hDEADBEEF);
    chk("tp1_err", {31'b0, o_err}, 0);
    chk("tp1_be", {28'b0, o_be}, 32'hF);

    // Byte store in the top lane.
    do_txn(1'b1, DRAM_WR_B, 32'h203, 32'h000000A5, '0, '0, 0, 0, 0, 0, acc);
    chk("tp2_latency", o_resp_cyc - acc, 2);
    chk("tp2_addr", o_addr, 32'h200);
    chk("tp2_be", {28'b0, o_be}, 32'h8);
    chk("tp2_wdata", o_wd, 32'hA5A5A5A5);

    // Half at offset 1, then word at offset 2.
    snap = o_req_cycles;
    do_txn(1'b0, DRAM_RD_H, 32'h101, $urandom, 32'h11223344, 32'h0, 0, 0, 0, 0, acc);
`ifdef LSU_SPLIT_EN
    chk("tp3_be", {28'b0, o_be}, 32'h6);
    chk("tp3_rdata", o_rd, 32'h00002233);
`else
    chk("tp3_err", {31'b0, o_err}, 1);
    chk("tp3_latency", o_resp_cyc - acc, 1);
`endif
    snap = o_req_cycles;
    do_txn(1'b0, DRAM_RD_W, 32'h102, $urandom, 32'hAABBCCDD, 32'h11223344, 0, 0, 0, 0, acc);
`ifdef LSU_SPLIT_EN
    chk("tp4_rdata", o_rd, 32'h3344AABB);
    chk("tp4_beat1_addr", o_addr, 32'h104);
    chk("tp4_beat1_be", {28'b0, o_be}, 32'h3);
    chk("tp4_latency", o_resp_cyc - acc, 5);
`else
    chk("tp4_err", {31'b0, o_err}, 1);
    chk("tp4_latency", o_resp_cyc - acc, 1);
    chk("tp4_no_mem_req", o_req_cycles - snap, 0);
`endif

    // Grant never comes: abort after TIMEOUT request cycles.
    snap = o_req_cycles;
    do_txn(1'b1, DRAM_WR_W, 32'h300, $urandom, '0, '0, 1000, 0, 0, 0, acc);
    chk("tp5_req_cycles", o_req_cycles - snap, TO);
    chk("tp5_err", {31'b0, o_err}, 1);
    chk("tp5_latency", o_resp_cyc - acc, TO + 1);

    // Reset while waiting for read data, then a late rvalid.
    snap2 = o_resp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_sel = DRAM_RD_W; req_addr = 32'h40;
    mem_rvalid = 1'b0;
    step();
    req_valid = 1'b0;
    expect_cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 4'hF, '0, 1'b0, 1'b0, '0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    expect_cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_idle();
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    step();
    mem_rvalid = 1'b0;
    step();
    chk("tp6_no_resp", o_resp_cnt, snap2);

    // Randomized traffic, back-to-back or with idle gaps.
    for (int t = 0; t < 400; t++) begin
      we = bit'($urandom_range(0, 1));
      if (we) begin
        case ($urandom_range(0, 2))
          0: sel = DRAM_WR_B;
          1: sel = DRAM_WR_H;
          default: sel = DRAM_WR_W;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0: sel = DRAM_RD_B;
          1: sel = DRAM_RD_BU;
          2: sel = DRAM_RD_H;
          3: sel = DRAM_RD_HU;
          default: sel = DRAM_RD_W;
        endcase
      end
      do_txn(we, sel, $urandom, $urandom, $urandom, $urandom,
             pick_delay(), pick_delay(), pick_delay(), pick_delay(), acc);
      repeat ($urandom_range(0, 2)) begin
        step();
        expect_idle();
        noise();
      end
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
